fmc_bus_initiator: RTL and testbench

- Synthesizable initiator for the asynchronous SRAM-style external memory bus (Mode 1 timing: NE/NOE/NWE/NBL, 20-bit address, 16-bit data) that our LED frontend answers as a responder.
- Converts single-word read/write requests on a valid/ready interface into correctly timed bus cycles.
- Used in the bench-side host FPGA and in loopback bring-up against the LED frontend register map (STAT=0, CTRL=1, DATA=2).

---
 rtl/fmc_pkg.sv | 31 +++
 rtl/fmc_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_fmc_bus_initiator.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmc_pkg.sv
// Shared definitions for the external memory bus initiator: FSM states,
// default Mode 1 phase lengths and the LED frontend register map.
package fmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DATA,
        ST_HOLD,
        ST_TURN
    } fmc_state_e;

    localparam int FMC_ADDSET_DEF  = 2;
    localparam int FMC_DATAST_DEF  = 4;
    localparam int FMC_BUSTURN_DEF = 1;

    // LED frontend responder register offsets (word addresses)
    localparam int LED_REG_STAT = 0;
    localparam int LED_REG_CTRL = 1;
    localparam int LED_REG_DATA = 2;
    localparam int LED_REG_RSV0 = 3;

    localparam int STRIPS = 72;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fmc_bus_initiator.sv
// SRAM-style (Mode 1) external bus initiator: turns single-word valid/ready
// requests into NE/NOE/NWE/NBL bus cycles with fully registered bus outputs.
module fmc_bus_initiator
    import fmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int ADDSET     = FMC_ADDSET_DEF,
    parameter int DATAST     = FMC_DATAST_DEF,
    parameter int BUSTURN    = FMC_BUSTURN_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_be,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] fmc_addr,
    output logic [DATA_WIDTH-1:0] fmc_dout,
    output logic                  fmc_doe,
    input  logic [DATA_WIDTH-1:0] fmc_din,
    output logic                  fmc_ne,
    output logic                  fmc_noe,
    output logic                  fmc_nwe,
    output logic [1:0]            fmc_nbl
);

    localparam int CNT_W = $clog2(max3(ADDSET, DATAST, BUSTURN) + 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(ADDSET - 1);
    localparam logic [CNT_W-1:0] DATA_LD  = CNT_W'(DATAST - 1);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'((BUSTURN > 0) ? BUSTURN - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fmc_state_e state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [1:0]            be_q, be_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  doe_q, doe_d;
    logic                  ne_q, ne_d;
    logic                  noe_q, noe_d;
    logic                  nwe_q, nwe_d;
    logic [1:0]            nbl_q, nbl_d;
    logic                  busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        be_d    = be_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;

        // One down-counter serves every timed phase; it reloads on phase entry.
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    wr_d    = req_write;
                    be_d    = req_be;
                    addr_d  = req_addr;
                    if (req_write) begin
                        dout_d = req_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    if (!wr_q) begin
                        rdata_d = fmc_din;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (BUSTURN > 0) begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus pins are decoded from the next state so they are registered
        // and line up with the state they belong to.
        busy_d  = (state_d == ST_SETUP) || (state_d == ST_DATA) || (state_d == ST_HOLD);
        ne_d    = !busy_d;
        doe_d   = busy_d && wr_d;
        noe_d   = !((state_d == ST_DATA) && !wr_d);
        nwe_d   = !((state_d == ST_DATA) && wr_d);
        nbl_d   = busy_d ? (wr_d ? ~be_d : 2'b00) : 2'b11;
        done_d  = (state_d == ST_HOLD);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= 2'b00;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            ne_q    <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            nbl_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            ne_q    <= ne_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            nbl_q   <= nbl_d;
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign fmc_addr  = addr_q;
    assign fmc_dout  = dout_q;
    assign fmc_doe   = doe_q;
    assign fmc_ne    = ne_q;
    assign fmc_noe   = noe_q;
    assign fmc_nwe   = nwe_q;
    assign fmc_nbl   = nbl_q;

endmodule

// File: tb/tb_fmc_bus_initiator.sv
// Scoreboard bench for fmc_bus_initiator with a responder memory model and a
// cycle-level reference model of the bus timing.
module tb_fmc_bus_initiator;
    import fmc_pkg::*;

    localparam int AW = 20;
    localparam int AS = FMC_ADDSET_DEF;
    localparam int DS = FMC_DATAST_DEF;
    localparam int BT = FMC_BUSTURN_DEF;
    localparam int T_HOLD  = AS + DS + 1;
    localparam int T_TOTAL = AS + DS + BT + 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [15:0]   req_wdata = '0;
    logic [1:0]    req_be    = 2'b00;
    logic          req_ready, done, fmc_doe, fmc_ne, fmc_noe, fmc_nwe;
    logic [15:0]   rdata, fmc_dout, fmc_din;
    logic [AW-1:0] fmc_addr;
    logic [1:0]    fmc_nbl;

    fmc_bus_initiator dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .done(done), .rdata(rdata),
        .fmc_addr(fmc_addr), .fmc_dout(fmc_dout), .fmc_doe(fmc_doe), .fmc_din(fmc_din),
        .fmc_ne(fmc_ne), .fmc_noe(fmc_noe), .fmc_nwe(fmc_nwe), .fmc_nbl(fmc_nbl)
    );

    // Second instance with no turnaround, always requesting writes.
    logic          b_ready, b_done, b_doe, b_ne, b_noe, b_nwe;
    logic [15:0]   b_rdata, b_dout;
    logic [AW-1:0] b_addr;
    logic [1:0]    b_nbl;

    fmc_bus_initiator #(.BUSTURN(0)) dut_b0 (
        .clk(clk), .resetn(resetn),
        .req_valid(1'b1), .req_ready(b_ready), .req_write(1'b1),
        .req_addr(20'd2), .req_wdata(16'h0000), .req_be(2'b11),
        .done(b_done), .rdata(b_rdata),
        .fmc_addr(b_addr), .fmc_dout(b_dout), .fmc_doe(b_doe), .fmc_din(16'h0000),
        .fmc_ne(b_ne), .fmc_noe(b_noe), .fmc_nwe(b_nwe), .fmc_nbl(b_nbl)
    );

    int checks = 0;
    int failures = 0;

    // Responder: drives read data only while NOE is low, captures on NWE rise.
    logic [15:0] resp_mem [16];
    assign fmc_din = fmc_noe ? 16'hDEAD : resp_mem[fmc_addr[3:0]];

    // Reference model state.
    int          cyc = 0;
    int          next_free = 0;
    int          last_acc = -1;
    bit          rst_seen = 1'b0;
    bit          cur_v = 1'b0;
    int          cur_A = 0;
    bit          cur_wr = 1'b0;
    logic [1:0]  cur_be = 2'b00;
    logic [15:0] cur_prev = '0;
    logic [AW-1:0] last_addr = '0;
    logic [15:0] last_dout = '0;
    logic [15:0] last_rd = '0;
    logic [15:0] model_mem [16];

    typedef struct packed { logic wr; logic [15:0] rd; } done_t;
    typedef struct packed { logic [AW-1:0] a; logic [15:0] d; logic [1:0] nbl; } cap_t;
    done_t done_q[$];
    cap_t  cap_q[$];

    always @(posedge clk) begin
        done_t de;
        cap_t  ce;
        cyc++;
        if (!resetn) begin
            rst_seen = 1'b1;
            if (cur_v && cur_wr && (cyc - cur_A) <= AS + DS)
                model_mem[last_addr[3:0]] = cur_prev;
            cur_v = 1'b0;
            last_addr = '0;
            last_dout = '0;
            last_rd = '0;
            next_free = cyc + 1;
            done_q.delete();
            cap_q.delete();
        end else if (req_valid && cyc >= next_free) begin
            last_acc = cyc;
            cur_v = 1'b1;
            cur_A = cyc;
            cur_wr = req_write;
            cur_be = req_be;
            last_addr = req_addr;
            next_free = cyc + T_TOTAL;
            if (req_write) begin
                last_dout = req_wdata;
                cur_prev = model_mem[req_addr[3:0]];
                if (req_be[0]) model_mem[req_addr[3:0]][7:0]  = req_wdata[7:0];
                if (req_be[1]) model_mem[req_addr[3:0]][15:8] = req_wdata[15:8];
                ce.a = req_addr; ce.d = req_wdata; ce.nbl = ~req_be;
                cap_q.push_back(ce);
                de.wr = 1'b1; de.rd = last_rd;
            end else begin
                last_rd = model_mem[req_addr[3:0]];
                de.wr = 1'b0; de.rd = last_rd;
            end
            done_q.push_back(de);
        end
    end

    // Cycle-level check of every output against the access timeline.
    always @(negedge clk) begin
        int k;
        logic act, dat;
        logic [43:0] exp_v, got_v;
        if (rst_seen) begin
            k   = cur_v ? (cyc - cur_A + 1) : 0;
            act = cur_v && (k >= 1) && (k <= T_HOLD);
            dat = cur_v && (k >= AS + 1) && (k <= AS + DS);
            exp_v = {(cyc + 1 >= next_free), (act && k == T_HOLD), ~act,
                     ~(dat && !cur_wr), ~(dat && cur_wr), (act && cur_wr),
                     (act ? (cur_wr ? ~cur_be : 2'b00) : 2'b11), last_addr, last_dout};
            got_v = {req_ready, done, fmc_ne, fmc_noe, fmc_nwe, fmc_doe,
                     fmc_nbl, fmc_addr, fmc_dout};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL bus cyc=%0d k=%0d {rdy,done,ne,noe,nwe,doe,nbl,addr,dout} got=%h exp=%h",
                         cyc, k, got_v, exp_v);
            end
        end
    end

    // Scoreboard monitor: each done pulse consumes one expected completion.
    always @(negedge clk) begin
        done_t e;
        if (rst_seen && done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected rdata=%h", rdata);
            end else begin
                e = done_q.pop_front();
                if (rdata !== e.rd) begin
                    failures++;
                    $display("FAIL rdata wr=%0b got=%h exp=%h", e.wr, rdata, e.rd);
                end
            end
        end
    end

    // Responder capture on NWE rising edge; writes aborted by reset are dropped.
    always @(posedge fmc_nwe) begin
        cap_t e;
        if (rst_seen && resetn) begin
            if (!fmc_nbl[0]) resp_mem[fmc_addr[3:0]][7:0]  = fmc_dout[7:0];
            if (!fmc_nbl[1]) resp_mem[fmc_addr[3:0]][15:8] = fmc_dout[15:8];
            checks++;
            if (cap_q.size() == 0) begin
                failures++;
                $display("FAIL capture_unexpected addr=%h data=%h", fmc_addr, fmc_dout);
            end else begin
                e = cap_q.pop_front();
                if ({fmc_addr, fmc_dout, fmc_nbl} !== {e.a, e.d, e.nbl}) begin
                    failures++;
                    $display("FAIL capture got addr=%h data=%h nbl=%b exp addr=%h data=%h nbl=%b",
                             fmc_addr, fmc_dout, fmc_nbl, e.a, e.d, e.nbl);
                end
            end
        end
    end

    // NE run lengths on the BUSTURN=0 instance.
    int b_hi = 0;
    int b_lo = 0;
    bit b_seen_lo = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            b_hi = 0; b_lo = 0; b_seen_lo = 1'b0;
        end else if (b_ne == 1'b0) begin
            if (b_hi > 0 && b_seen_lo) begin
                checks++;
                if (b_hi != 1) begin
                    failures++;
                    $display("FAIL b0_ne_gap got=%0d exp=1", b_hi);
                end
            end
            b_hi = 0; b_lo++; b_seen_lo = 1'b1;
        end else begin
            if (b_lo > 0) begin
                checks++;
                if (b_lo != AS + DS + 1) begin
                    failures++;
                    $display("FAIL b0_ne_low got=%0d exp=%0d", b_lo, AS + DS + 1);
                end
            end
            b_lo = 0; b_hi++;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                         input logic [1:0] be, input bit drop);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (last_acc == cyc) break;
        end
        if (last_acc != cyc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout addr=%h", a);
        end
        if (drop) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && (cyc + 1 < next_free); i++) step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            resp_mem[i] = v;
            model_mem[i] = v;
        end
        resetn = 1'b0;
        step(3);
        resetn = 1'b1;

        issue(1'b1, AW'(LED_REG_CTRL), 16'h0001, 2'b11, 1'b1);
        wait_idle();

        resp_mem[0] = 16'h000F;
        model_mem[0] = 16'h000F;
        issue(1'b0, AW'(LED_REG_STAT), 16'h0000, 2'b00, 1'b1);
        wait_idle();

        issue(1'b1, 20'd5, 16'hAB00, 2'b10, 1'b1);
        wait_idle();
        issue(1'b0, 20'd5, 16'h0000, 2'b00, 1'b1);
        wait_idle();

        for (int i = 0; i < STRIPS; i++)
            issue(1'b1, AW'(LED_REG_DATA), 16'(i + 16'h0100), 2'b11, 1'b0);
        req_valid = 1'b0;
        wait_idle();
        issue(1'b0, AW'(LED_REG_DATA), 16'h0000, 2'b00, 1'b1);
        wait_idle();

        // Reset during the fourth cycle of a write.
        issue(1'b1, 20'd7, 16'h1234, 2'b11, 1'b1);
        step(3);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        issue(1'b0, 20'd7, 16'h0000, 2'b00, 1'b1);
        wait_idle();
        issue(1'b1, 20'd7, 16'h4321, 2'b11, 1'b1);
        wait_idle();

        // Stray pulse during an access, then a request held until idle.
        issue(1'b1, 20'd3, 16'h5555, 2'b01, 1'b1);
        step(2);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'hFFFFF;
        step(1);
        req_valid = 1'b0; req_addr = 20'h00009;
        step(1);
        issue(1'b0, 20'd9, 16'h0000, 2'b00, 1'b1);
        wait_idle();

        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom),
                  2'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                step(1);
                req_valid = 1'b1;
                req_write = 1'($urandom_range(0, 1));
                req_addr = AW'($urandom);
                req_wdata = 16'($urandom);
                step(1);
                req_valid = 1'b0;
            end
            step($urandom_range(0, 3));
        end
        req_valid = 1'b0;
        wait_idle();
        step(4);

        checks++;
        if (done_q.size() != 0) begin
            failures++;
            $display("FAIL done_pending got=%0d exp=0", done_q.size());
        end
        checks++;
        if (cap_q.size() != 0) begin
            failures++;
            $display("FAIL capture_pending got=%0d exp=0", cap_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
